// File: rtl/exception_handler_pkg.sv
// Shared definitions for the exception handler and the software-side status-code encoder:
// exception codes, FSM state encoding and the default status register index.
package exception_handler_pkg;

    localparam logic [4:0] STATUS_REG_DEFAULT = 5'd30;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_ADD  = 3'd1;
    localparam logic [2:0] EXC_ADDI = 3'd2;
    localparam logic [2:0] EXC_SUB  = 3'd3;
    localparam logic [2:0] EXC_MUL  = 3'd4;
    localparam logic [2:0] EXC_DIV  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HANDLER  = 2'd3
    } excState_t;

    // Any value outside EXC_ADD..EXC_DIV is an ordinary software write to the status register.
    function automatic logic isExcCode(input logic [31:0] data);
        return (data >= {29'd0, EXC_ADD}) && (data <= {29'd0, EXC_DIV});
    endfunction

endpackage

// File: rtl/exception_handler_exc_counter.sv
// 8-bit saturating event counter with synchronous reset.
module exc_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    output logic [7:0] count
);

    localparam logic [7:0] COUNT_MAX = 8'hFF;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 8'd0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/exception_handler.sv
// Watches writeback for exception status codes, then flushes the pipeline, redirects fetch
// to the handler vector and waits for the handler to return.
module exception_handler
    import exception_handler_pkg::*;
#(
    parameter logic [31:0] HANDLER_BASE = 32'h0000_1000,
    parameter logic [4:0]  STATUS_REG   = STATUS_REG_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        redirect_ack,
    input  logic        eret,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic [2:0]  exc_code,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  exc_count,
    output logic [1:0]  dbgState
);

    // Handshake: redirect is the valid, redirect_ack the ready. redirect and redirect_pc stay
    // stable from the first REDIRECT cycle until the edge that samples redirect_ack=1; that
    // edge completes the transfer. redirect_ack while redirect=0 has no effect.

    excState_t   state;
    excState_t   nextState;
    logic        excEvent;
    logic        capture;
    logic        lost;
    logic [2:0]  nextCode;

    assign excEvent = wb_we && (wb_rd == STATUS_REG) && isExcCode(wb_data);
    assign nextCode = capture ? wb_data[2:0] : exc_code;
    assign dbgState = state;

    always_comb begin
        nextState = state;
        capture   = 1'b0;
        lost      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (excEvent) begin
                    capture   = 1'b1;
                    nextState = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                lost      = excEvent;
                nextState = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                lost = excEvent;
                if (redirect_ack) begin
                    nextState = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                // A return and a new exception in the same cycle chain straight into the next capture.
                if (eret) begin
                    if (excEvent) begin
                        capture   = 1'b1;
                        nextState = ST_FLUSH;
                    end else begin
                        nextState = ST_IDLE;
                    end
                end else begin
                    lost = excEvent;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            exc_code    <= EXC_NONE;
            epc         <= 32'd0;
            redirect_pc <= HANDLER_BASE;
        end else begin
            state       <= nextState;
            flush       <= (nextState == ST_FLUSH);
            redirect    <= (nextState == ST_REDIRECT);
            busy        <= (nextState != ST_IDLE);
            if (lost) begin
                overrun <= 1'b1;
            end
            if (capture) begin
                exc_code <= wb_data[2:0];
                epc      <= wb_pc;
            end
            redirect_pc <= HANDLER_BASE + {25'd0, nextCode, 4'd0};
        end
    end

    exc_counter excCounter (
        .clock (clock),
        .reset (reset),
        .inc   (capture),
        .count (exc_count)
    );

endmodule

// File: doc/exception_handler.md
EXCEPTION_HANDLER -- requirements
Module: exception_handler

Interface
REQ-001 Parameter HANDLER_BASE, default 32'h0000_1000: base address of the exception handler vector table.
REQ-002 Parameter STATUS_REG, default 5'd30: register index that carries exception status codes.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wb_we  input  1  writeback register-write enable.
REQ-006 wb_rd  input  5  writeback destination register.
REQ-007 wb_data  input  32  writeback data.
REQ-008 wb_pc  input  32  PC of the instruction in writeback.
REQ-009 redirect_ack  input  1  fetch stage has accepted the redirect.
REQ-010 eret  input  1  handler return strobe, one cycle.
REQ-011 flush  output  1  squash all younger pipeline instructions.
REQ-012 redirect  output  1  PC redirect request.
REQ-013 redirect_pc  output  32  handler entry address.
REQ-014 epc  output  32  saved PC of the faulting instruction.
REQ-015 exc_code  output  3  latched exception code.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 overrun  output  1  sticky: exception lost while busy.
REQ-018 exc_count  output  8  saturating count of captured exceptions.

Function
REQ-019 Valid exception event: wb_we=1, wb_rd=STATUS_REG and wb_data in 1..5 (1 add, 2 addi, 3 sub, 4 mul, 5 div).
REQ-020 Any other wb_data on a STATUS_REG write (0, 6..2^32-1) is an ordinary software write and is ignored.
REQ-021 FSM states: IDLE, FLUSH, REDIRECT, HANDLER; all outputs registered.
REQ-022 IDLE + valid event at edge N: exc_code<=wb_data[2:0], epc<=wb_pc, exc_count incremented, next state FLUSH; flush=1 during cycle N+1 only.
REQ-023 FLUSH -> REDIRECT unconditionally after one cycle; redirect=1 from cycle N+2.
REQ-024 REDIRECT: redirect held high and redirect_pc held stable until the edge that samples redirect_ack=1; next state HANDLER.
REQ-025 redirect_pc = HANDLER_BASE + (exc_code << 4), modulo 2^32; it is driven in every state, but is meaningful only while redirect=1.
REQ-026 HANDLER: hold until eret=1, then go to IDLE; epc and exc_code stay valid until the next capture.
REQ-027 eret in IDLE, FLUSH or REDIRECT is ignored.
REQ-028 Valid event in FLUSH, REDIRECT or HANDLER (without eret) sets overrun=1; the event is not captured and exc_count is unchanged.
REQ-029 HANDLER with eret and a valid event in the same cycle: the event is captured per REQ-022 and the next state is FLUSH; overrun is unchanged.
REQ-030 redirect_ack while redirect=0 is ignored.
REQ-031 exc_count saturates at 8'hFF and never wraps.
REQ-032 overrun is cleared only by reset.

Reset
REQ-033 reset=1 at an edge: state IDLE; flush, redirect, busy and overrun = 0; exc_code=0; epc=0; exc_count=0; redirect_pc=HANDLER_BASE.
REQ-034 reset overrides all other inputs in any state; mid-handshake it drops redirect and flush on the next cycle.

Structure
REQ-035 A shared package holds the EXC_ADD..EXC_DIV code constants, the 2-bit FSM state encoding and the STATUS_REG default; the encoder that writes the status codes uses the same package.
REQ-036 One sub-module, exc_counter: an 8-bit saturating counter with increment enable and synchronous reset.

Verification
REQ-037 IDLE; write r30=2 with wb_pc=0x40; ack in 3rd REDIRECT cycle -> flush one cycle, redirect 3 cycles, redirect_pc=0x1020, epc=0x40, exc_code=2, exc_count=1.
REQ-038 Write r30=0 and r30=7 -> no state change; busy=0; exc_count=0.
REQ-039 In HANDLER, write r30=4 without eret -> overrun=1, exc_code unchanged; in the same run, eret plus r30=5 together -> FLUSH, exc_code=5, redirect_pc=0x1050.
REQ-040 Assert reset while in REDIRECT -> next cycle redirect=0, busy=0, exc_count=0, overrun=0.
REQ-041 Run 300 back-to-back handled exceptions -> exc_count reaches 8'hFF and stays there.
